instr_fetch_ctrl: RTL

- Memory initiator that drives the single-port synchronous RAM port (wdata/we/address/rdata, we: 0 = write, 1 = read, one-cycle registered read).
- Two modes:
  - LOAD: streams a program image into RAM from a byte-agnostic word source.
  - FETCH: sequentially reads instruction words from RAM, buffers them in a small FIFO and presents them to the decode stage over a valid/ready handshake, with branch redirect.
- Sits between the boot/loader path, the RAM and the core decode stage.

---
 rtl/instr_fetch_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: streams a program image into a single-port RAM
// (LOAD) and fetches sequential words into a small FIFO for decode (FETCH).
module instr_fetch_ctrl #(
  parameter int unsigned data_length = 32,
  parameter int unsigned mem_length  = 32,
  parameter int unsigned fifo_depth  = 2,
  localparam int unsigned AW = $clog2(mem_length)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_start,
  input  logic                   load_valid,
  input  logic [data_length-1:0] load_data,
  input  logic                   load_last,
  output logic                   load_ready,
  input  logic                   fetch_start,
  input  logic                   halt,
  input  logic                   redirect_valid,
  input  logic [AW-1:0]          redirect_addr,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [data_length-1:0] instr_data,
  output logic [AW-1:0]          instr_addr,
  output logic                   mem_we,
  output logic [AW-1:0]          mem_address,
  output logic [data_length-1:0] mem_wdata,
  input  logic [data_length-1:0] mem_rdata,
  output logic                   busy
);

  localparam int unsigned PW = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  localparam int unsigned CW = $clog2(fifo_depth + 1);
  localparam int unsigned SW = CW + 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(mem_length - 1);
  localparam logic [SW-1:0] DEPTH     = SW'(fifo_depth);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_FETCH = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [AW-1:0]          r_pc;
  logic [AW-1:0]          r_waddr;
  logic [AW-1:0]          r_tag;
  logic                   r_pending;
  logic [PW-1:0]          r_wptr;
  logic [PW-1:0]          r_rptr;
  logic [CW-1:0]          r_count;
  logic [data_length-1:0] r_fifo_data [fifo_depth];
  logic [AW-1:0]          r_fifo_addr [fifo_depth];

  logic          w_issue;
  logic          w_flush;
  logic          w_redirect;
  logic          w_write;
  logic          w_enter_load;
  logic          w_enter_fetch;
  logic          w_pop_req;
  logic          w_push;
  logic          w_pop;
  logic          w_credit;
  logic [AW-1:0] w_pc_inc;

  assign instr_valid = (r_count != '0);
  assign instr_data  = r_fifo_data[r_rptr];
  assign instr_addr  = r_fifo_addr[r_rptr];

  // A pop this cycle frees a slot, so issue can continue at one word per cycle.
  assign w_pop_req = instr_valid & instr_ready;
  assign w_credit  = (SW'(r_count) + SW'(r_pending)) < (DEPTH + SW'(w_pop_req));
  assign w_push    = (r_state == S_FETCH) & r_pending & ~w_flush;
  assign w_pop     = w_pop_req & ~w_flush;
  assign w_pc_inc  = (r_pc == LAST_ADDR) ? '0 : r_pc + AW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_issue       = 1'b0;
    w_flush       = 1'b0;
    w_redirect    = 1'b0;
    w_write       = 1'b0;
    w_enter_load  = 1'b0;
    w_enter_fetch = 1'b0;
    load_ready    = 1'b0;
    busy          = 1'b1;
    mem_we        = 1'b1;
    mem_address   = r_pc;
    mem_wdata     = '0;
    unique case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (load_start) begin
          w_state_nxt  = S_LOAD;
          w_enter_load = 1'b1;
        end else if (fetch_start) begin
          w_state_nxt   = S_FETCH;
          w_enter_fetch = 1'b1;
        end
      end
      S_LOAD: begin
        load_ready  = 1'b1;
        mem_address = r_waddr;
        if (load_valid) begin
          w_write   = 1'b1;
          mem_we    = 1'b0;
          mem_wdata = load_data;
        end
        if (halt) begin
          w_state_nxt = S_IDLE;
          w_flush     = 1'b1;
        end else if (load_valid && (load_last || (r_waddr == LAST_ADDR))) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_FETCH: begin
        if (halt) begin
          w_state_nxt = S_IDLE;
          w_flush     = 1'b1;
        end else if (redirect_valid) begin
          w_flush    = 1'b1;
          w_redirect = 1'b1;
        end else begin
          w_issue = w_credit;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Address counters, in-flight tag and FIFO bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc      <= '0;
      r_waddr   <= '0;
      r_tag     <= '0;
      r_pending <= 1'b0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
    end else begin
      if (w_enter_load)  r_waddr <= '0;
      else if (w_write)  r_waddr <= r_waddr + AW'(1);

      if (w_enter_fetch)   r_pc <= '0;
      else if (w_redirect) r_pc <= redirect_addr;
      else if (w_issue)    r_pc <= w_pc_inc;

      r_pending <= w_issue;
      if (w_issue) r_tag <= r_pc;

      if (w_flush) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + PW'(1);
        if (w_pop)  r_rptr <= r_rptr + PW'(1);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  // Storage needs no reset: entries are only visible through r_count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_data[r_wptr] <= mem_rdata;
      r_fifo_addr[r_wptr] <= r_tag;
    end
  end

endmodule
